// File: rtl/core_ctrl.sv
// Multi-cycle control FSM for a simple RV32 core: fetch/decode/exec/mem/wb sequencing,
// PC and retired-instruction bookkeeping, and a sticky trap state.
module core_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] pc,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_q,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  input  logic        branch_taken,
  input  logic [31:0] target_pc,
  output logic [2:0]  state_o,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_LUI, C_SYS, C_ILL
  } cls_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_d;
  logic [31:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;
  logic        imem_req_q, imem_req_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic        rf_we_q, rf_we_d;
  logic        halted_q, halted_d;
  logic        commit;
  cls_t        cls;

  // instr_q is stable from DECODE until commit, so the class is decoded from it directly.
  always_comb begin
    cls = C_ILL;
    case (instr_q[6:0])
      7'b0110011: cls = C_R;
      7'b0010011: cls = C_I;
      7'b0000011: cls = C_LOAD;
      7'b0100011: cls = C_STORE;
      7'b1100011: cls = C_BRANCH;
      7'b1101111: cls = C_JAL;
      7'b0110111: cls = C_LUI;
      7'b1110011: cls = C_SYS;
      default:    cls = C_ILL;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    commit    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (cls)
          C_ILL: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
          C_SYS:   state_d = S_TRAP;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            commit  = 1'b1;
            state_d = S_FETCH;
          end
          C_ILL, C_SYS: state_d = S_TRAP;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (cls == C_STORE) begin
            commit  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        commit  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    instret_d = instret_q;
    if (commit) begin
      if ((cls == C_JAL) || ((cls == C_BRANCH) && branch_taken)) pc_d = target_pc;
      else pc_d = pc_q + 32'd4;
      instret_d = instret_q + 32'd1;
    end
  end

  // Strobes are registered from the next state so they line up with state_q.
  always_comb begin
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    dmem_we_d  = (state_d == S_MEM) && (cls == C_STORE);
    rf_we_d    = (state_d == S_WB);
    halted_d   = (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instret_q  <= 32'd0;
      illegal_q  <= 1'b0;
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instret_q  <= instret_d;
      illegal_q  <= illegal_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req = imem_req_q;
  assign pc       = pc_q;
  assign dmem_req = dmem_req_q;
  assign dmem_we  = dmem_we_q;
  assign rf_we    = rf_we_q;
  assign state_o  = state_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl: expected commits are queued by the stimulus and
// checked by an independent monitor when instret advances.
module tb_core_ctrl;

  localparam logic [31:0] OP_ADD   = 32'h0020_81B3;
  localparam logic [31:0] OP_ADDI  = 32'h0010_8093;
  localparam logic [31:0] OP_LW    = 32'h0000_A103;
  localparam logic [31:0] OP_SW    = 32'h0020_A023;
  localparam logic [31:0] OP_BEQ   = 32'h0000_0063;
  localparam logic [31:0] OP_JAL   = 32'h0000_006F;
  localparam logic [31:0] OP_LUI   = 32'h0000_10B7;
  localparam logic [31:0] OP_ECALL = 32'h0000_0073;
  localparam logic [31:0] OP_BAD   = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, imem_valid = 1'b0;
  logic [31:0] pc, imem_rdata = 32'd0, instr_q;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic        rf_we, branch_taken = 1'b0;
  logic [31:0] target_pc = 32'd0;
  logic [2:0]  state_o;
  logic        halted, illegal;
  logic [31:0] instret;

  core_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .pc(pc),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr_q(instr_q),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .branch_taken(branch_taken), .target_pc(target_pc),
    .state_o(state_o), .halted(halted), .illegal(illegal), .instret(instret)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    int cyc;
    int ifc;
    int rf;
    int dm;
    int we;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] prog[64];
  int          i_delay = 0;
  int          d_delay = 0;
  logic [31:0] prev_instret = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] ir, input int cyc,
                      input int ifc, input int rf, input int dm, input int we);
    exp_t e;
    e.pc = p; e.ir = ir; e.cyc = cyc; e.ifc = ifc; e.rf = rf; e.dm = dm; e.we = we;
    sbq.push_back(e);
  endtask

  task automatic clear_prog();
    for (int k = 0; k < 64; k++) prog[k] = OP_ADDI;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_instret(input logic [31:0] n, input int budget);
    int k = 0;
    while (instret !== n && k < budget) begin
      @(posedge clk);
      #1 k++;
    end
    if (instret !== n) begin
      checks++;
      errors++;
      $display("FAIL timeout_instret actual=%h required=%h", instret, n);
    end
    @(negedge clk);
    #2;
  endtask

  // Memory responder: fixed-latency handshakes, valid/ready left high outside
  // their own states when the latency is zero so the DUT must ignore them.
  initial begin
    int fcnt = 0;
    int dcnt = 0;
    forever begin
      @(negedge clk);
      imem_rdata = prog[pc[7:2]];
      if (imem_req && rst_n) begin
        imem_valid = (fcnt >= i_delay);
        fcnt++;
      end else begin
        fcnt = 0;
        imem_valid = (i_delay == 0);
      end
      if (dmem_req && rst_n) begin
        dmem_ready = (dcnt >= d_delay);
        dcnt++;
      end else begin
        dcnt = 0;
        dmem_ready = (d_delay == 0);
      end
    end
  end

  // Monitor: accumulates per-instruction activity and checks it on each commit.
  initial begin
    int acc_cyc = 0, acc_if = 0, acc_rf = 0, acc_dm = 0, acc_we = 0;
    logic        last_hs = 1'b0;
    logic [31:0] last_data = 32'd0;
    logic [31:0] prev_instr = 32'd0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        acc_cyc = 0; acc_if = 0; acc_rf = 0; acc_dm = 0; acc_we = 0;
        last_hs = 1'b0;
        prev_instr = instr_q;
        prev_instret = instret;
      end else begin
        if (instret !== prev_instret) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit actual=pc %h instret %h required=no commit", pc, instret);
          end else begin
            e = sbq.pop_front();
            chk("commit_pc", pc, e.pc);
            chk("commit_instret", instret, e.ir);
            chk("commit_cycles", acc_cyc, e.cyc);
            chk("commit_imem_req_cycles", acc_if, e.ifc);
            chk("commit_rf_we_pulses", acc_rf, e.rf);
            chk("commit_dmem_req_cycles", acc_dm, e.dm);
            chk("commit_dmem_we_cycles", acc_we, e.we);
          end
          acc_cyc = 0; acc_if = 0; acc_rf = 0; acc_dm = 0; acc_we = 0;
          prev_instret = instret;
        end
        if (instr_q !== prev_instr) begin
          chk("instr_q_only_on_handshake", {31'd0, last_hs}, 32'd1);
          chk("instr_q_value", instr_q, last_data);
          prev_instr = instr_q;
        end
        last_hs   = imem_req && imem_valid;
        last_data = imem_rdata;
        acc_cyc++;
        if (imem_req) acc_if++;
        if (rf_we) acc_rf++;
        if (dmem_req) acc_dm++;
        if (dmem_req && dmem_we) acc_we++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int k;
    clear_prog();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_pc", pc, 32'd0);
    chk("reset_instr_q", instr_q, 32'd0);
    chk("reset_instret", instret, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_state", {29'd0, state_o}, 32'd0);

    // Zero-wait mix: every class, JAL and taken BEQ both redirect to 0x40.
    prog[0] = OP_ADD; prog[1] = OP_ADDI; prog[2] = OP_LUI; prog[3] = OP_JAL;
    prog[16] = OP_SW; prog[17] = OP_LW; prog[18] = OP_BEQ;
    target_pc = 32'h40; branch_taken = 1'b1; i_delay = 0; d_delay = 0;
    push(32'h04, 1, 4, 1, 1, 0, 0);
    push(32'h08, 2, 4, 1, 1, 0, 0);
    push(32'h0C, 3, 4, 1, 1, 0, 0);
    push(32'h40, 4, 4, 1, 1, 0, 0);
    push(32'h44, 5, 4, 1, 0, 1, 1);
    push(32'h48, 6, 5, 1, 1, 1, 0);
    push(32'h40, 7, 3, 1, 0, 0, 0);
    release_reset();
    wait_instret(7, 200);
    chk("p1_drained", sbq.size(), 0);

    // Wait states: fetch latency 3, data latency 2, branch not taken.
    rst_n = 1'b0;
    clear_prog();
    prog[0] = OP_SW; prog[1] = OP_LW; prog[2] = OP_BEQ; prog[3] = OP_ADD;
    branch_taken = 1'b0; i_delay = 3; d_delay = 2;
    push(32'h04, 1, 9, 4, 0, 3, 3);
    push(32'h08, 2, 10, 4, 1, 3, 0);
    push(32'h0C, 3, 6, 4, 0, 0, 0);
    push(32'h10, 4, 7, 4, 1, 0, 0);
    release_reset();
    wait_instret(4, 300);
    chk("p2_drained", sbq.size(), 0);

    // Illegal opcode after one good instruction.
    rst_n = 1'b0;
    clear_prog();
    prog[0] = OP_ADD; prog[1] = OP_BAD;
    i_delay = 0; d_delay = 0;
    push(32'h04, 1, 4, 1, 1, 0, 0);
    release_reset();
    wait_instret(1, 100);
    repeat (10) @(posedge clk);
    #1;
    chk("trap_halted", {31'd0, halted}, 32'd1);
    chk("trap_illegal", {31'd0, illegal}, 32'd1);
    chk("trap_pc", pc, 32'h04);
    chk("trap_instret", instret, 32'd1);
    chk("trap_state", {29'd0, state_o}, 32'd5);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      #1 if (imem_req || dmem_req || rf_we) bad++;
    end
    chk("trap_quiet", bad, 0);

    // ECALL traps without the illegal flag.
    rst_n = 1'b0;
    #1 chk("reset_clears_illegal", {31'd0, illegal}, 32'd0);
    clear_prog();
    prog[0] = OP_ECALL;
    release_reset();
    repeat (8) @(posedge clk);
    #1;
    chk("ecall_halted", {31'd0, halted}, 32'd1);
    chk("ecall_illegal", {31'd0, illegal}, 32'd0);
    chk("ecall_pc", pc, 32'h00);
    chk("ecall_instret", instret, 32'd0);

    // Reset pulsed in the middle of a stalled load.
    rst_n = 1'b0;
    clear_prog();
    prog[0] = OP_ADD; prog[1] = OP_LW;
    d_delay = 10;
    push(32'h04, 1, 4, 1, 1, 0, 0);
    release_reset();
    k = 0;
    while (!dmem_req && k < 50) begin
      @(posedge clk);
      #1 k++;
    end
    chk("mem_reached", {31'd0, dmem_req}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midmem_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("midmem_pc", pc, 32'd0);
    chk("midmem_instret", instret, 32'd0);
    chk("midmem_state", {29'd0, state_o}, 32'd0);
    d_delay = 0;
    push(32'h04, 1, 4, 1, 1, 0, 0);
    push(32'h08, 2, 5, 1, 1, 1, 0);
    release_reset();
    wait_instret(2, 100);
    chk("p5_drained", sbq.size(), 0);

    // instret wraps from all-ones to zero on commit.
    rst_n = 1'b0;
    clear_prog();
    prog[0] = OP_ADD;
    push(32'h04, 0, 4, 1, 1, 0, 0);
    release_reset();
    dut.instret_q = 32'hFFFF_FFFF;
    prev_instret = 32'hFFFF_FFFF;
    wait_instret(0, 100);
    chk("wrap_pc", pc, 32'h04);
    chk("final_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
